// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, opcode/funct codes, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Primary opcodes decoded by control
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BNE     = 6'h05;

  // SPECIAL funct codes
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  // Word offset to byte offset, sign-extended to 32 bits
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: halt > jump (J/JAL or JR) > taken branch > pc+4.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is committed.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_halt,
  input  logic        i_jump,
  input  logic        i_jump_sel,
  input  logic [25:0] i_jump_target,
  input  logic [31:0] i_jr_addr,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_imm,
  output logic [31:0] o_next_pc,
  output logic        o_fault
);

  logic [31:0] w_pc_plus4;

  // Priority redirect mux; a misaligned JR keeps the pc and flags a fault
  always_comb begin
    w_pc_plus4 = i_pc + 32'd4;
    o_next_pc  = w_pc_plus4;
    o_fault    = 1'b0;
    if (i_halt) begin
      o_next_pc = i_pc;
    end else if (i_jump) begin
      if (i_jump_sel) begin
        if (i_jr_addr[1:0] != 2'b00) begin
          o_fault   = 1'b1;
          o_next_pc = i_pc;
        end else begin
          o_next_pc = i_jr_addr;
        end
      end else begin
        o_next_pc = {w_pc_plus4[31:28], i_jump_target, 2'b00};
      end
    end else if (i_branch_taken) begin
      o_next_pc = w_pc_plus4 + branch_offset(i_branch_imm);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: imem req/ack read, then valid/ready issue to decode.
// Latency: 2 cycles per instruction with zero-wait memory, +1 per wait cycle.
// Backpressure: instruction held stable in ISSUE until instr_ready; no fetch meanwhile.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        jump_sel,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_addr,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        halt,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instret
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_halted;
  logic         r_fault;
  logic [31:0]  r_instret;
  logic         r_run;
  logic [31:0]  w_next_pc;
  logic         w_fault;
  logic         w_accept;
  logic         w_capture;

  next_pc_calc u_next_pc_calc (
    .i_pc           (r_pc),
    .i_halt         (halt),
    .i_jump         (jump),
    .i_jump_sel     (jump_sel),
    .i_jump_target  (jump_target),
    .i_jr_addr      (jr_addr),
    .i_branch_taken (branch_taken),
    .i_branch_imm   (branch_imm),
    .o_next_pc      (w_next_pc),
    .o_fault        (w_fault)
  );

  assign w_accept  = (r_state == ST_ISSUE) && instr_ready;
  assign w_capture = (r_state == ST_FETCH) && r_run && imem_ack;

  assign imem_addr = r_pc;
  assign instr     = r_instr;
  assign opcode    = r_instr[31:26];
  assign funct     = r_instr[5:0];
  assign pc_out    = r_pc;
  assign pc_plus4  = r_pc + 32'd4;
  assign halted    = r_halted;
  assign fault     = r_fault;
  assign instret   = r_instret;

  // Keeps imem_req low while reset is held; goes high on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = r_run;
        if (w_capture) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        if (w_accept) w_state_nxt = (halt || w_fault) ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // Datapath: capture fetched word, commit pc/counters/status on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_halted  <= 1'b0;
      r_fault   <= 1'b0;
      r_instret <= 32'd0;
    end else begin
      if (w_capture) r_instr <= imem_rdata;
      if (w_accept) begin
        r_instret <= r_instret + 32'd1;
        r_pc      <= w_next_pc;
        if (halt || w_fault) r_halted <= 1'b1;
        if (w_fault)         r_fault  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the MIPS core, sitting directly upstream of the control decoder. Holds the program counter, fetches one 32-bit word per instruction from instruction memory over a req/ack handshake, and presents the instruction plus its opcode/funct fields to decode with a valid/ready handshake. It applies jump, JR, branch and halt redirects returned by control/ALU at the moment decode accepts an instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, always equal to pc
- imem_ack  in  1  read data valid this cycle; ignored while imem_req=0
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr/opcode/funct/pc_out valid
- instr_ready  in  1  decode accepts the presented instruction
- instr  out  32  captured instruction word
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- pc_out  out  32  address of presented instruction
- pc_plus4  out  32  pc_out+4 (JAL link value)
- jump  in  1  redirect via jump; sampled on accept
- jump_sel  in  1  0 = J/JAL target, 1 = JR register target
- jump_target  in  26  instr_index for J/JAL
- jr_addr  in  32  register value for JR
- branch_taken  in  1  BNE resolved taken; sampled on accept
- branch_imm  in  16  branch offset, words, signed
- halt  in  1  SYSCALL decoded; sampled on accept
- halted  out  1  fetch stopped
- fault  out  1  misaligned JR target detected
- instret  out  32  count of accepted instructions

## Operation
- States: FETCH, ISSUE, HALT.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, -> ISSUE. No ack: stay; address held stable.
- ISSUE: instr_valid=1, imem_req=0, outputs held stable until accept (instr_valid & instr_ready).
- On accept: instret<=instret+1 (wraps at 2^32); pc<=next_pc; -> FETCH, unless halt or fault below.
- next_pc priority: halt > jump > branch_taken > sequential.
  - sequential: pc+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
  - jump, jump_sel=0: {pc_plus4[31:28], jump_target, 2'b00}.
  - jump, jump_sel=1: jr_addr; if jr_addr[1:0]!=0 -> fault=1, -> HALT, pc unchanged.
  - branch_taken: pc_plus4 + (sign-extended branch_imm << 2), mod 2^32.
- halt on accept: -> HALT, pc unchanged, halted=1.
- HALT: imem_req=0, instr_valid=0; held until rst_n low. fault and halted sticky.
- Redirect inputs ignored outside the accept cycle.

## Timing
- Reset (rst_n=0, asynchronous): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0 while held, halted=0, fault=0, instret=0. imem_req rises in the first cycle after rst_n deasserts.
- imem_ack accepted in the same cycle imem_req first rises (zero-wait memory): instr_valid high the next cycle.
- Minimum throughput: one instruction per 2 cycles (FETCH, ISSUE); each memory wait cycle adds one.
- instr_ready high in ISSUE's first cycle: accepted that cycle, no extra latency.
- opcode, funct, pc_plus4 are combinational from registered instr/pc_out; no glitch while instr_valid=1.
- Reset mid-fetch or mid-issue: captured word discarded; an ack arriving during reset ignored.

## Structure
- Shared package mips_pkg: fetch state enum; opcode/funct constants (J, JAL, JR, BNE, SYSCALL) shared with control; RESET_PC default.
- One sub-module, next_pc_calc: combinational next_pc and fault from pc, redirect inputs; unit-testable alone.

## Test plan
- Reset release, zero-wait memory, instr_ready=1: imem_addr 0, 4, 8; instr_valid every other cycle; instret=3 after three accepts.
- 2-cycle ack delay: imem_addr held at 0x4 for all wait cycles; instr_valid only after ack; instr matches rdata.
- pc=0x0040_0010 branch_taken, branch_imm=16'hFFFE: next imem_addr=0x0040_000C; branch_imm=3 -> 0x0040_0020.
- J at pc=0x1000_0000, jump_target=26'h000_0040: next imem_addr=0x1000_0100; JR jr_addr=0x0000_0200 -> 0x200; JR jr_addr=0x202 -> fault=1, halted... no fetch, imem_req=0.
- halt with jump=1 on same accept: HALT wins; halted=1, imem_req=0, instr_valid=0 for 10 cycles.
- rst_n pulsed low during memory wait at pc=0x8: pc=RESET_PC, instret=0, fetch restarts at 0; pc=0xFFFF_FFFC sequential wraps to 0.
